// File: rtl/snitch_dma_req_scheduler.sv
// Shares one DMA backend among NrCores cores: round-robin admission into a
// descriptor FIFO, in-order issue, and per-core completion tracking.
module snitch_dma_req_scheduler #(
  parameter int unsigned NrCores        = 8,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned ReqFifoDepth   = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdxW           = (NrCores > 1) ? $clog2(NrCores) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrCores-1:0]            req_valid_i,
  output logic [NrCores-1:0]            req_ready_o,
  input  logic [NrCores*AddrWidth-1:0]  req_src_i,
  input  logic [NrCores*AddrWidth-1:0]  req_dst_i,
  input  logic [NrCores*LenWidth-1:0]   req_len_i,
  output logic                          be_valid_o,
  input  logic                          be_ready_i,
  output logic [AddrWidth-1:0]          be_src_o,
  output logic [AddrWidth-1:0]          be_dst_o,
  output logic [LenWidth-1:0]           be_len_o,
  output logic [IdxW-1:0]               be_core_o,
  input  logic                          be_done_i,
  output logic [NrCores-1:0]            done_o,
  output logic [NrCores-1:0]            busy_o,
  output logic                          err_o
);

  localparam int unsigned FifoPtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned FifoCntW = $clog2(ReqFifoDepth + 1);
  localparam int unsigned InfPtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned InfCntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned CntW     = $clog2(ReqFifoDepth + MaxOutstanding + 1);
  localparam int unsigned SumW     = IdxW + 1;

  function automatic logic [FifoPtrW-1:0] fifo_ptr_inc(input logic [FifoPtrW-1:0] p);
    return (p == FifoPtrW'(ReqFifoDepth - 1)) ? '0 : p + FifoPtrW'(1);
  endfunction

  function automatic logic [InfPtrW-1:0] inf_ptr_inc(input logic [InfPtrW-1:0] p);
    return (p == InfPtrW'(MaxOutstanding - 1)) ? '0 : p + InfPtrW'(1);
  endfunction

  logic [IdxW-1:0]      rr_ptr, win;
  logic [SumW-1:0]      rr_sum;
  logic                 found, full, push, issue, done_pop;
  logic [AddrWidth-1:0] src_w, dst_w;
  logic [LenWidth-1:0]  len_w;
  logic [NrCores-1:0]   done_vec;

  logic [AddrWidth-1:0] fifo_src  [ReqFifoDepth];
  logic [AddrWidth-1:0] fifo_dst  [ReqFifoDepth];
  logic [LenWidth-1:0]  fifo_len  [ReqFifoDepth];
  logic [IdxW-1:0]      fifo_core [ReqFifoDepth];
  logic [FifoPtrW-1:0]  wr_ptr, rd_ptr;
  logic [FifoCntW-1:0]  fifo_cnt;

  logic [IdxW-1:0]      inf_core [MaxOutstanding];
  logic [InfPtrW-1:0]   inf_wr, inf_rd;
  logic [InfCntW-1:0]   inf_cnt;
  logic [IdxW-1:0]      inf_head;

  // Round-robin search starting at rr_ptr, wrapping modulo NrCores
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_sum = '0;
    for (int i = 0; i < NrCores; i++) begin
      rr_sum = SumW'(rr_ptr) + SumW'(i);
      if (rr_sum >= SumW'(NrCores)) rr_sum = rr_sum - SumW'(NrCores);
      if (!found && req_valid_i[rr_sum[IdxW-1:0]]) begin
        found = 1'b1;
        win   = rr_sum[IdxW-1:0];
      end
    end
  end

  always_comb begin
    src_w = '0;
    dst_w = '0;
    len_w = '0;
    for (int c = 0; c < NrCores; c++) begin
      if (win == IdxW'(c)) begin
        src_w = req_src_i[c*AddrWidth +: AddrWidth];
        dst_w = req_dst_i[c*AddrWidth +: AddrWidth];
        len_w = req_len_i[c*LenWidth +: LenWidth];
      end
    end
  end

  // Full uses the registered count, so a pop in this cycle never frees a slot early
  assign full       = (fifo_cnt == FifoCntW'(ReqFifoDepth));
  assign push       = found && !full && rst_ni;
  assign be_valid_o = (fifo_cnt != '0) && (inf_cnt < InfCntW'(MaxOutstanding));
  assign issue      = be_valid_o && be_ready_i;
  assign done_pop   = be_done_i && (inf_cnt != '0);
  assign inf_head   = inf_core[inf_rd];

  assign be_src_o  = fifo_src[rd_ptr];
  assign be_dst_o  = fifo_dst[rd_ptr];
  assign be_len_o  = fifo_len[rd_ptr];
  assign be_core_o = fifo_core[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_src[wr_ptr]  <= src_w;
      fifo_dst[wr_ptr]  <= dst_w;
      fifo_len[wr_ptr]  <= len_w;
      fifo_core[wr_ptr] <= win;
    end
    if (issue) inf_core[inf_wr] <= fifo_core[rd_ptr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inf_wr   <= '0;
      inf_rd   <= '0;
      inf_cnt  <= '0;
      done_o   <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (win == IdxW'(NrCores - 1)) ? '0 : win + IdxW'(1);
        wr_ptr <= fifo_ptr_inc(wr_ptr);
      end
      if (issue) rd_ptr <= fifo_ptr_inc(rd_ptr);
      if (push && !issue)      fifo_cnt <= fifo_cnt + FifoCntW'(1);
      else if (!push && issue) fifo_cnt <= fifo_cnt - FifoCntW'(1);

      if (issue)    inf_wr <= inf_ptr_inc(inf_wr);
      if (done_pop) inf_rd <= inf_ptr_inc(inf_rd);
      if (issue && !done_pop)      inf_cnt <= inf_cnt + InfCntW'(1);
      else if (!issue && done_pop) inf_cnt <= inf_cnt - InfCntW'(1);

      done_o <= done_vec;
      if (be_done_i && (inf_cnt == '0)) err_o <= 1'b1;
    end
  end

  // Per-core outstanding count covers both queued and in-flight descriptors
  for (genvar c = 0; c < NrCores; c++) begin : g_core
    logic [CntW-1:0] cnt_q;
    logic            inc, dec;

    assign inc            = push && (win == IdxW'(c));
    assign dec            = done_pop && (inf_head == IdxW'(c));
    assign req_ready_o[c] = inc;
    assign done_vec[c]    = dec;
    assign busy_o[c]      = (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             cnt_q <= '0;
      else if (inc && !dec)    cnt_q <= cnt_q + CntW'(1);
      else if (dec && !inc)    cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: tb/tb_snitch_dma_req_scheduler.sv
// Bench for snitch_dma_req_scheduler: directed vector tables, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
module tb_snitch_dma_req_scheduler;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int IW = 3;
  localparam int FIFO_D = 3;
  localparam int MAX_OS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_src, req_dst;
  logic [N*LW-1:0] req_len;
  logic            be_valid, be_ready, be_done;
  logic [AW-1:0]   be_src, be_dst;
  logic [LW-1:0]   be_len;
  logic [IW-1:0]   be_core;
  logic [N-1:0]    done, busy;
  logic            err;

  logic [AW-1:0] src_a [N];
  logic [AW-1:0] dst_a [N];
  logic [LW-1:0] len_a [N];

  always_comb begin
    req_src = '0;
    req_dst = '0;
    req_len = '0;
    for (int c = 0; c < N; c++) begin
      req_src[c*AW +: AW] = src_a[c];
      req_dst[c*AW +: AW] = dst_a[c];
      req_len[c*LW +: LW] = len_a[c];
    end
  end

  snitch_dma_req_scheduler dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_src_i   (req_src),
    .req_dst_i   (req_dst),
    .req_len_i   (req_len),
    .be_valid_o  (be_valid),
    .be_ready_i  (be_ready),
    .be_src_o    (be_src),
    .be_dst_o    (be_dst),
    .be_len_o    (be_len),
    .be_core_o   (be_core),
    .be_done_i   (be_done),
    .done_o      (done),
    .busy_o      (busy),
    .err_o       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: descriptor queue, in-flight core queue, per-core counts
  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    int            core;
  } desc_t;

  desc_t        m_fifo [$];
  int           m_infl [$];
  int           m_cnt  [N];
  int           m_rr;
  logic [N-1:0] m_done;
  bit           m_err;
  bit           m_hs, m_iss;
  int           m_win;

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    m_rr = 0; m_done = '0; m_err = 0;
    m_hs = 0; m_iss = 0; m_win = -1;
  endtask

  function automatic int m_winner();
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_rr + i) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_bev();
    return (m_fifo.size() > 0) && (m_infl.size() < MAX_OS);
  endfunction

  task automatic model_check();
    int w;
    logic [N-1:0] er, eb;
    w = m_winner();
    er = '0;
    if (w >= 0 && m_fifo.size() < FIFO_D) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("be_valid", be_valid, m_bev());
    if (m_bev()) begin
      chk("be_src", be_src, m_fifo[0].src);
      chk("be_dst", be_dst, m_fifo[0].dst);
      chk("be_len", be_len, m_fifo[0].len);
      chk("be_core", be_core, m_fifo[0].core);
    end
    for (int c = 0; c < N; c++) eb[c] = (m_cnt[c] != 0);
    chk("done", done, m_done);
    chk("busy", busy, eb);
    chk("err", err, m_err);
  endtask

  task automatic model_step();
    logic [N-1:0] nd;
    bit dn;
    int h;
    desc_t d;
    m_win = m_winner();
    m_hs  = (m_win >= 0) && (m_fifo.size() < FIFO_D);
    m_iss = m_bev() && be_ready;
    dn    = be_done && (m_infl.size() > 0);
    nd    = '0;
    if (dn) begin
      h = m_infl.pop_front();
      nd[h] = 1'b1;
      m_cnt[h]--;
    end else if (be_done) begin
      m_err = 1;
    end
    if (m_iss) begin
      d = m_fifo.pop_front();
      m_infl.push_back(d.core);
    end
    if (m_hs) begin
      d.src = src_a[m_win]; d.dst = dst_a[m_win]; d.len = len_a[m_win]; d.core = m_win;
      m_fifo.push_back(d);
      m_cnt[m_win]++;
      m_rr = (m_win + 1) % N;
    end
    m_done = nd;
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    #1;
    finish_cycle();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = '0; be_ready = 1'b0; be_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] valid;
    bit           ber;
    bit           bdone;
    logic [N-1:0] ready;
    bit           bev;
    int           core;
    logic [N-1:0] done;
    logic [N-1:0] busy;
    bit           err;
  } vec_t;

  vec_t tv [$];

  task automatic add(input bit r, input logic [N-1:0] v, input bit br, input bit bd,
                     input logic [N-1:0] rdy, input bit bv, input int co,
                     input logic [N-1:0] dn, input logic [N-1:0] bs, input bit e);
    vec_t t;
    t.rst = r; t.valid = v; t.ber = br; t.bdone = bd; t.ready = rdy;
    t.bev = bv; t.core = co; t.done = dn; t.busy = bs; t.err = e;
    tv.push_back(t);
  endtask

  int issues;
  int rem [N];
  int grants [$];
  int dones  [$];
  bit next_done;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Single transfer from core 3, then FIFO-full backpressure from cores 0-5
    add(1, 8'h00, 0, 0, 8'h00, 0, -1, 8'h00, 8'h00, 0);
    add(0, 8'h08, 1, 0, 8'h08, 0, -1, 8'h00, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 1,  3, 8'h00, 8'h08, 0);
    add(0, 8'h00, 1, 1, 8'h00, 0, -1, 8'h00, 8'h08, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, -1, 8'h08, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0, -1, 8'h00, 8'h00, 0);
    add(1, 8'h3F, 0, 0, 8'h01, 0, -1, 8'h00, 8'h00, 0);
    add(0, 8'h3F, 0, 0, 8'h02, 1,  0, 8'h00, 8'h01, 0);
    add(0, 8'h3F, 0, 0, 8'h04, 1,  0, 8'h00, 8'h03, 0);
    add(0, 8'h3F, 0, 0, 8'h00, 1,  0, 8'h00, 8'h07, 0);
    add(0, 8'h3F, 1, 0, 8'h00, 1,  0, 8'h00, 8'h07, 0);
    add(0, 8'h3F, 0, 0, 8'h08, 1,  1, 8'h00, 8'h07, 0);
    add(0, 8'h3F, 0, 0, 8'h00, 1,  1, 8'h00, 8'h0F, 0);

    for (int c = 0; c < N; c++) begin
      src_a[c] = 32'h0001_0000 * (c + 1);
      dst_a[c] = 32'h8000_0000 + 32'h100 * c;
      len_a[c] = 32'(16 * c);
    end
    src_a[3] = 32'h1000; dst_a[3] = 32'h2000; len_a[3] = 32'd64;

    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].rst) reset_dut();
      req_valid = tv[k].valid; be_ready = tv[k].ber; be_done = tv[k].bdone;
      #1;
      chk("tv_ready", req_ready, tv[k].ready);
      chk("tv_be_valid", be_valid, tv[k].bev);
      if (tv[k].core >= 0) chk("tv_be_core", be_core, tv[k].core);
      chk("tv_done", done, tv[k].done);
      chk("tv_busy", busy, tv[k].busy);
      chk("tv_err", err, tv[k].err);
      finish_cycle();
    end

    // Round-robin fairness with all cores requesting, four descriptors each
    reset_dut();
    for (int c = 0; c < N; c++) rem[c] = 4;
    req_valid = '1; be_ready = 1'b1; be_done = 1'b0;
    for (int cyc = 0; cyc < 400 && dones.size() < 4 * N; cyc++) begin
      #1;
      for (int c = 0; c < N; c++) begin
        if (done[c]) dones.push_back(c);
        if (req_ready[c]) grants.push_back(c);
      end
      finish_cycle();
      next_done = m_iss;
      if (m_hs) begin
        rem[m_win]--;
        if (rem[m_win] == 0) req_valid[m_win] = 1'b0;
      end
      be_done = next_done;
    end
    be_done = 1'b0;
    chk("rr_grant_count", grants.size(), 4 * N);
    chk("rr_done_count", dones.size(), 4 * N);
    for (int k = 0; k < grants.size(); k++) chk("rr_grant_order", grants[k], k % N);
    for (int k = 0; k < dones.size(); k++) chk("rr_done_order", dones[k], k % N);

    // Outstanding limit: four issues, then stall until a completion frees a slot
    reset_dut();
    req_valid = 8'h01; be_ready = 1'b1; issues = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (be_valid && be_ready) issues++;
      finish_cycle();
    end
    chk("os_issues", issues, MAX_OS);
    chk("os_be_valid_stall", be_valid, 1'b0);
    chk("os_fifo_full_ready", req_ready, 8'h00);
    chk("os_busy", busy, 8'h01);
    be_done = 1'b1;
    #1;
    chk("os_stall_during_done", be_valid, 1'b0);
    finish_cycle();
    #1;
    chk("os_issue_with_done", be_valid, 1'b1);
    if (be_valid) issues++;
    finish_cycle();
    be_done = 1'b0;
    chk("os_issues_after", issues, MAX_OS + 1);
    chk("os_done_core0", done, 8'h01);

    // Spurious completion sets sticky err; async reset mid-transfer clears everything
    reset_dut();
    be_done = 1'b1;
    #1;
    chk("err_before", err, 1'b0);
    finish_cycle();
    be_done = 1'b0;
    chk("err_set", err, 1'b1);
    repeat (3) cycle();
    chk("err_sticky", err, 1'b1);
    req_valid = 8'h08; be_ready = 1'b1;
    cycle();
    cycle();
    be_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 8'h00);
    chk("rst_be_valid", be_valid, 1'b0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_done", done, 8'h00);
    chk("rst_err", err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    cycle();

    // Randomized traffic against the reference model
    reset_dut();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      be_ready = ($urandom_range(0, 3) != 0);
      be_done  = (m_infl.size() > 0) && ($urandom_range(0, 2) == 0);
      for (int c = 0; c < N; c++) begin
        if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
          req_valid[c] = 1'b1;
          src_a[c] = $urandom;
          dst_a[c] = $urandom;
          len_a[c] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        end
      end
      cycle();
      if (m_hs) req_valid[m_win] = 1'b0;
    end
    be_done = 1'b0;
    req_valid = '0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
